// File: rtl/qf_rfm_ctl.sv
// qf_rfm_ctl: zero-fill sequencer and round-robin two-port arbiter for the FCB register-file memory
module qf_rfm_ctl #(
  parameter int PAR_MEMORY_WIDTH_BIT = 64,
  parameter int PAR_MEMORY_DEPTH_BIT = 4,
  parameter bit PAR_INIT_EN = 1'b1
) (
  input  logic                            rfm_clk,
  input  logic                            rfm_rst,
  input  logic                            req_a,
  input  logic                            we_a,
  input  logic [PAR_MEMORY_DEPTH_BIT-1:0] addr_a,
  input  logic [PAR_MEMORY_WIDTH_BIT-1:0] wdata_a,
  output logic                            gnt_a,
  output logic                            rvalid_a,
  output logic [PAR_MEMORY_WIDTH_BIT-1:0] rdata_a,
  input  logic                            req_b,
  input  logic                            we_b,
  input  logic [PAR_MEMORY_DEPTH_BIT-1:0] addr_b,
  input  logic [PAR_MEMORY_WIDTH_BIT-1:0] wdata_b,
  output logic                            gnt_b,
  output logic                            rvalid_b,
  output logic [PAR_MEMORY_WIDTH_BIT-1:0] rdata_b,
  output logic                            init_done,
  output logic                            rfm_wr_en,
  output logic [PAR_MEMORY_DEPTH_BIT-1:0] rfm_wr_addr,
  output logic [PAR_MEMORY_WIDTH_BIT-1:0] rfm_wr_data,
  output logic [PAR_MEMORY_DEPTH_BIT-1:0] rfm_rd_addr,
  input  logic [PAR_MEMORY_WIDTH_BIT-1:0] rfm_rd_data
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;
  logic [PAR_MEMORY_DEPTH_BIT-1:0] cnt;
  logic [PAR_MEMORY_WIDTH_BIT-1:0] rdata;
  logic last_b, run, fill, rd_a, rd_b;
  assign init_done = state == RUN;
  assign rdata_a = rdata;
  assign rdata_b = rdata;
  // last_b set means B was granted most recently, so A wins the next contention
  always_comb begin
    run = state == RUN && !rfm_rst;
    fill = PAR_INIT_EN && state == INIT && !rfm_rst;
    gnt_a = run && req_a && (!req_b || last_b);
    gnt_b = run && req_b && !gnt_a;
    rd_a = gnt_a && !we_a;
    rd_b = gnt_b && !we_b;
    rfm_wr_en = fill || (gnt_a && we_a) || (gnt_b && we_b);
    rfm_wr_addr = fill ? cnt : gnt_a ? addr_a : gnt_b ? addr_b : '0;
    rfm_wr_data = (gnt_a && we_a) ? wdata_a : (gnt_b && we_b) ? wdata_b : '0;
    rfm_rd_addr = rd_a ? addr_a : rd_b ? addr_b : '0;
    state_nxt = (state == RUN || !PAR_INIT_EN || &cnt) ? RUN : INIT;
  end
  always_ff @(posedge rfm_clk) begin
    if (rfm_rst) begin
      state <= INIT;
      cnt <= '0;
      rdata <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      last_b <= 1'b1;
    end else begin
      state <= state_nxt;
      if (fill) cnt <= cnt + 1'b1;
      if (rd_a || rd_b) rdata <= rfm_rd_data;
      rvalid_a <= rd_a;
      rvalid_b <= rd_b;
      if (gnt_a) last_b <= 1'b0;
      else if (gnt_b) last_b <= 1'b1;
    end
  end
endmodule
